// File: rtl/vga_controller.sv
// VGA timing generator: divides clk to the pixel rate, runs h/v position counters,
// and decodes sync, active-area coordinates, end-of-screen pulse and gated colour.
module vga_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525,
  parameter int CLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] color_in,
  output logic        screenend,
  output logic        active,
  output logic [9:0]  active_x,
  output logic [9:0]  active_y,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_VIS_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
  // Sync windows end where the back porch begins.
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_TOTAL - H_BACK);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_TOTAL - V_BACK);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [9:0]       h_cnt_reg, h_cnt_next;
  logic [9:0]       v_cnt_reg, v_cnt_next;
  logic             pix_tick;
  logic [23:0]      rgb;

  assign pix_tick = (div_cnt_reg == DIV_LAST);

  always_comb begin
    div_cnt_next = pix_tick ? '0 : div_cnt_reg + 1'b1;
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    if (pix_tick) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
      end else begin
        h_cnt_next = h_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
    end
  end

  assign active    = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
  assign active_x  = active ? h_cnt_reg : 10'd0;
  assign active_y  = active ? v_cnt_reg : 10'd0;
  assign hsync     = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
  assign vsync     = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
  assign screenend = pix_tick && (h_cnt_reg == H_VIS_LAST) && (v_cnt_reg == V_VIS_LAST);

  // Blank each colour channel outside the visible area.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb[gi*8 +: 8] = active ? color_in[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign {red, green, blue} = rgb;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: an elapsed-clock arithmetic model checked every cycle,
// plus literal expectations for pulse positions, sync widths and colour gating.
module tb_vga_controller;

  localparam int HA = 20, HF = 1, HS = 2, HB = 3, HT = 26;
  localparam int VA = 30, VF = 1, VS = 2, VB = 3, VT = 36;
  localparam int CD = 4;
  localparam int LINE  = HT * CD;   // 104 clocks
  localparam int FRAME = LINE * VT; // 3744 clocks

  typedef struct packed {
    logic       se;
    logic       act;
    logic [9:0] ax;
    logic [9:0] ay;
    logic       hs;
    logic       vs;
    logic [23:0] rgb;
  } vga_out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] color_in = 24'hA1B2C3;
  logic        screenend, active, hsync, vsync;
  logic [9:0]  active_x, active_y;
  logic [7:0]  red, green, blue;

  int errors = 0;
  int checks = 0;
  int n = 0;  // clocks elapsed since reset release

  int hs_low_line0, vs_low_frame0, act_frame0, first_ax1;
  int se_q[$];
  logic [23:0] cap_act_rgb, cap_blank_rgb;
  logic [23:0] colors [4];

  vga_controller #(HA, HF, HS, HB, HT, VA, VF, VS, VB, VT, CD) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .color_in  (color_in),
    .screenend (screenend),
    .active    (active),
    .active_x  (active_x),
    .active_y  (active_y),
    .hsync     (hsync),
    .vsync     (vsync),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic vga_out_t model(input int cnt, input logic [23:0] c);
    vga_out_t o;
    int sub, h, v;
    sub = cnt % CD;
    h   = (cnt / CD) % HT;
    v   = (cnt / LINE) % VT;
    o.act = (h < HA) && (v < VA);
    o.ax  = o.act ? 10'(h) : 10'd0;
    o.ay  = o.act ? 10'(v) : 10'd0;
    o.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    o.se  = (sub == CD - 1) && (h == HA - 1) && (v == VA - 1);
    o.rgb = o.act ? c : 24'h0;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  task automatic clear_stats();
    hs_low_line0  = 0;
    vs_low_frame0 = 0;
    act_frame0    = 0;
    first_ax1     = -1;
    se_q.delete();
  endtask

  // Per-cycle comparison against the model, plus event tallies for the first frame.
  initial begin
    vga_out_t e;
    forever begin
      @(negedge clk);
      e = model(n, color_in);
      check("screenend", screenend, e.se);
      check("active", active, e.act);
      check("active_x", active_x, e.ax);
      check("active_y", active_y, e.ay);
      check("hsync", hsync, e.hs);
      check("vsync", vsync, e.vs);
      check("rgb", {red, green, blue}, e.rgb);
      if (rst_n) begin
        if (screenend) se_q.push_back(n);
        if (n < FRAME) begin
          if (!hsync && n < LINE) hs_low_line0++;
          if (!vsync) vs_low_frame0++;
          if (active) act_frame0++;
        end
        if (active_x == 10'd1 && first_ax1 < 0) first_ax1 = n;
        if (n == 10) cap_act_rgb = {red, green, blue};
        if (n == 90) cap_blank_rgb = {red, green, blue};
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    colors[0] = 24'hFFFFFF;
    colors[1] = 24'h000001;
    colors[2] = 24'h123456;
    colors[3] = 24'h800080;
    clear_stats();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_active", active, 1);
    check("rst_active_x", active_x, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_screenend", screenend, 0);
    check("rst_rgb", {red, green, blue}, 24'hA1B2C3);
    @(posedge clk);
    #2 rst_n = 1'b1;
    $display("phase 1: reset released, colour A1B2C3");

    while (n < FRAME + 60) @(posedge clk);
    @(negedge clk);
    check("se_count_f1", se_q.size(), 1);
    if (se_q.size() >= 1) check("se_first_f1", se_q[0], 3095);
    check("hs_low_line0", hs_low_line0, 8);
    check("vs_low_frame0", vs_low_frame0, 208);
    check("active_frame0", act_frame0, 2400);
    check("first_ax1", first_ax1, 4);
    check("rgb_active", cap_act_rgb, 24'hA1B2C3);
    check("rgb_blank", cap_blank_rgb, 24'h0);
    $display("phase 1 done: screenend at %0d, hsync low %0d, vsync low %0d", (se_q.size() > 0) ? se_q[0] : -1, hs_low_line0, vs_low_frame0);

    while (n < FRAME + 12 * LINE + 37) @(posedge clk);
    #2 rst_n = 1'b0;
    clear_stats();
    @(negedge clk);
    check("midrst_active_x", active_x, 0);
    check("midrst_active_y", active_y, 0);
    check("midrst_active", active, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    $display("phase 2: mid-frame reset at line 12 released, rotating colours");

    while (n < 2 * FRAME + 20) begin
      @(posedge clk);
      #2 color_in = colors[(n / 5) % 4];
    end
    @(negedge clk);
    check("se_count_f2", se_q.size(), 2);
    if (se_q.size() >= 2) begin
      check("se_first_f2", se_q[0], 3095);
      check("se_second_f2", se_q[1], 3095 + FRAME);
    end
    check("hs_low_line0_f2", hs_low_line0, 8);
    check("vs_low_frame0_f2", vs_low_frame0, 208);
    check("active_frame0_f2", act_frame0, 2400);
    check("first_ax1_f2", first_ax1, 4);
    $display("phase 2 done: %0d screenend pulses", se_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
